// File: rtl/tron_pkg.sv
// Shared screen, arena and cell constants plus the collision reader state type.
package tron_pkg;

  localparam int unsigned H_RES       = 640;
  localparam int unsigned V_RES       = 480;
  localparam int unsigned ARENA_MIN_X = 16;
  localparam int unsigned ARENA_MAX_X = 623;
  localparam int unsigned ARENA_MIN_Y = 16;
  localparam int unsigned ARENA_MAX_Y = 463;
  localparam int unsigned CELL_W      = 8;
  localparam int unsigned CELL_H      = 8;
  localparam int unsigned ADDR_W      = 19;
  localparam int unsigned DATA_W      = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StResp
  } state_e;

endpackage

// File: rtl/read_valid_pipe.sv
// Shift register of read-valid tags that tracks reads in flight through the RAM port.
module read_valid_pipe #(
  parameter int unsigned Depth = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic tag_in,
  output logic tag_out,
  output logic busy,
  output logic pending
);

  logic [Depth-1:0] tags_q;

  generate
    if (Depth == 1) begin : g_single
      always_ff @(posedge CLOCK_50) begin
        if (reset) tags_q <= '0;
        else       tags_q <= tag_in;
      end
      assign pending = 1'b0;
    end else begin : g_multi
      always_ff @(posedge CLOCK_50) begin
        if (reset) tags_q <= '0;
        else       tags_q <= {tags_q[Depth-2:0], tag_in};
      end
      // Tags still in flight behind the one emerging this cycle.
      assign pending = |tags_q[Depth-2:0];
    end
  endgenerate

  assign tag_out = tags_q[Depth-1];
  assign busy    = |tags_q;

endmodule

// File: rtl/cell_collision_reader.sv
// Scans one player cell of the framebuffer and reports the first non-zero pixel or out-of-arena.
module cell_collision_reader
  import tron_pkg::*;
#(
  parameter int unsigned HRes      = H_RES,
  parameter int unsigned CellW     = CELL_W,
  parameter int unsigned CellH     = CELL_H,
  parameter int unsigned ArenaMinX = ARENA_MIN_X,
  parameter int unsigned ArenaMaxX = ARENA_MAX_X,
  parameter int unsigned ArenaMinY = ARENA_MIN_Y,
  parameter int unsigned ArenaMaxY = ARENA_MAX_Y,
  parameter int unsigned RdLatency = 2,
  parameter int unsigned AddrW     = ADDR_W,
  parameter int unsigned DataW     = DATA_W
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [9:0]        req_x,
  input  logic [9:0]        req_y,
  output logic              rd_en,
  output logic [AddrW-1:0]  rd_address,
  input  logic [DataW-1:0]  rd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_oob,
  output logic [DataW-1:0]  rsp_data
);

  localparam int unsigned ColW = (CellW > 1) ? $clog2(CellW) : 1;
  localparam int unsigned RowW = (CellH > 1) ? $clog2(CellH) : 1;

  state_e           state_q, state_d;
  logic [AddrW-1:0] row_base_q;
  logic [ColW-1:0]  col_q;
  logic [RowW-1:0]  row_q;
  logic             hit_q, oob_q;
  logic [DataW-1:0] data_q;
  logic             tag_out, busy, pending;
  logic             accept, last_rd, oob;
  logic [10:0]      x11, y11;
  logic [AddrW-1:0] row_base_init;

  // 11-bit compare so a cell near column 1023 cannot wrap back into the arena.
  assign x11    = {1'b0, req_x};
  assign y11    = {1'b0, req_y};
  assign oob    = (x11 < 11'(ArenaMinX)) || ((x11 + 11'(CellW - 1)) > 11'(ArenaMaxX)) ||
                  (y11 < 11'(ArenaMinY)) || ((y11 + 11'(CellH - 1)) > 11'(ArenaMaxY));
  assign row_base_init = AddrW'(req_x) + AddrW'(req_y) * AddrW'(HRes);
  assign accept  = req_valid && (state_q == StIdle);
  assign last_rd = (col_q == ColW'(CellW - 1)) && (row_q == RowW'(CellH - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = oob ? StResp : StIssue;
      StIssue: if (last_rd)   state_d = StDrain;
      // Leave as the final tag retires; its data is captured on the same edge.
      StDrain: if (!pending)  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    rd_en      = (state_q == StIssue);
    rd_address = rd_en ? (row_base_q + AddrW'(col_q)) : '0;
    rsp_valid  = (state_q == StResp);
    rsp_hit    = hit_q;
    rsp_oob    = oob_q;
    rsp_data   = data_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      row_base_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      hit_q      <= 1'b0;
      oob_q      <= 1'b0;
      data_q     <= '0;
    end else if (accept) begin
      row_base_q <= row_base_init;
      col_q      <= '0;
      row_q      <= '0;
      hit_q      <= oob;
      oob_q      <= oob;
      data_q     <= '0;
    end else begin
      if (rd_en) begin
        if (col_q == ColW'(CellW - 1)) begin
          col_q      <= '0;
          row_q      <= row_q + 1'b1;
          row_base_q <= row_base_q + AddrW'(HRes);
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (tag_out && (rd_data != '0) && !hit_q) begin
        hit_q  <= 1'b1;
        data_q <= rd_data;
      end
    end
  end

  read_valid_pipe #(
    .Depth (RdLatency)
  ) u_read_valid_pipe (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tag_in   (rd_en),
    .tag_out  (tag_out),
    .busy     (busy),
    .pending  (pending)
  );

endmodule

// File: tb/tb_cell_collision_reader.sv
// Directed scoreboard bench for cell_collision_reader with a 2-cycle framebuffer RAM model.
module tb_cell_collision_reader;
  import tron_pkg::*;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [9:0]  req_x = '0;
  logic [9:0]  req_y = '0;
  logic        req_ready, rd_en, rsp_valid, rsp_hit, rsp_oob;
  logic [18:0] rd_address;
  logic [7:0]  rd_data, rsp_data;

  logic [7:0]  mem [0:307199];
  logic [7:0]  p1 = '0;
  logic [7:0]  p2 = '0;

  typedef struct {
    int x;
    int y;
    int hit;
    int oob;
    int data;
    int lat;
    int reads;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    p1 <= mem[rd_address];
    p2 <= p1;
  end
  assign rd_data = p2;

  cell_collision_reader dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .rd_en      (rd_en),
    .rd_address (rd_address),
    .rd_data    (rd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_hit    (rsp_hit),
    .rsp_oob    (rsp_oob),
    .rsp_data   (rsp_data)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive a request that the next posedge accepts.
  task automatic push_req(input int x, input int y, input int hit, input int oob,
                          input int data, input int lat, input int reads);
    exp_t e;
    e = '{x: x, y: y, hit: hit, oob: oob, data: data, lat: lat, reads: reads};
    sb.push_back(e);
    chk("req_ready_before_accept", int'(req_ready), 1);
    req_valid = 1'b1;
    req_x     = 10'(x);
    req_y     = 10'(y);
  endtask

  task automatic collect(input int hold, input bit pend, input int px, input int py);
    exp_t e;
    int   cyc;
    int   nreads;
    int   addr;
    bit   done;
    e = sb[0];
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    req_x     = 10'($urandom);
    req_y     = 10'($urandom);
    cyc       = 1;
    nreads    = 0;
    done      = 1'b0;
    while (!done && cyc <= 200) begin
      if (rd_en) begin
        addr = (e.y + nreads / 8) * 640 + e.x + nreads % 8;
        chk("rd_address", int'(rd_address), addr);
        nreads++;
      end else begin
        chk("rd_address_idle", int'(rd_address), 0);
      end
      if (rsp_valid) done = 1'b1;
      else begin
        @(negedge CLOCK_50);
        cyc++;
      end
    end
    chk("rsp_timeout", int'(done), 1);
    if (done) begin
      e = sb.pop_front();
      chk("rsp_latency", cyc, e.lat);
      chk("read_count", nreads, e.reads);
      chk("rsp_hit", int'(rsp_hit), e.hit);
      chk("rsp_oob", int'(rsp_oob), e.oob);
      chk("rsp_data", int'(rsp_data), e.data);
    end
    for (int i = 0; i < hold; i++) begin
      if (pend) begin
        req_valid = 1'b1;
        req_x     = 10'(px);
        req_y     = 10'(py);
      end
      @(negedge CLOCK_50);
      chk("hold_rsp_valid", int'(rsp_valid), 1);
      chk("hold_req_ready", int'(req_ready), 0);
      chk("hold_rd_en", int'(rd_en), 0);
      chk("hold_hit", int'(rsp_hit), e.hit);
      chk("hold_data", int'(rsp_data), e.data);
    end
    rsp_ready = 1'b1;
    @(negedge CLOCK_50);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", int'(rsp_valid), 0);
    chk("back_to_idle", int'(req_ready), 1);
  endtask

  initial begin
    bit seen;
    foreach (mem[i]) mem[i] = 8'h00;

    repeat (3) @(negedge CLOCK_50);
    chk("reset_req_ready", int'(req_ready), 1);
    chk("reset_rd_en", int'(rd_en), 0);
    chk("reset_rd_address", int'(rd_address), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_hit", int'(rsp_hit), 0);
    chk("reset_rsp_oob", int'(rsp_oob), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    reset = 1'b0;
    @(negedge CLOCK_50);

    // Clear cell.
    push_req(216, 240, 0, 0, 0, 67, 64);
    collect(0, 1'b0, 0, 0);

    // Only the last pixel set.
    mem[223 + 247 * 640] = 8'h01;
    push_req(216, 240, 1, 0, 1, 67, 64);
    collect(0, 1'b0, 0, 0);
    mem[223 + 247 * 640] = 8'h00;

    // First non-zero in row-major order wins.
    mem[218 + 240 * 640] = 8'h80;
    mem[216 + 241 * 640] = 8'h01;
    push_req(216, 240, 1, 0, 8'h80, 67, 64);
    collect(0, 1'b0, 0, 0);
    mem[218 + 240 * 640] = 8'h00;
    mem[216 + 241 * 640] = 8'h00;

    // Bottom-right arena corner, pixel at the very last legal address.
    mem[623 + 463 * 640] = 8'h42;
    push_req(616, 456, 1, 0, 8'h42, 67, 64);
    collect(0, 1'b0, 0, 0);
    mem[623 + 463 * 640] = 8'h00;

    // Out of arena: immediate response, no reads.
    push_req(617, 240, 1, 1, 0, 1, 0);
    collect(0, 1'b0, 0, 0);
    push_req(8, 240, 1, 1, 0, 1, 0);
    collect(0, 1'b0, 0, 0);
    push_req(1020, 240, 1, 1, 0, 1, 0);
    collect(0, 1'b0, 0, 0);
    push_req(216, 10, 1, 1, 0, 1, 0);
    collect(0, 1'b0, 0, 0);

    // Backpressure with a request waiting behind the response.
    mem[300 + 203 * 640] = 8'h07;
    push_req(216, 240, 0, 0, 0, 67, 64);
    collect(10, 1'b1, 300, 200);
    push_req(300, 200, 1, 0, 7, 67, 64);
    collect(0, 1'b0, 0, 0);
    mem[300 + 203 * 640] = 8'h00;

    // Reset in the middle of the read burst.
    chk("pre_reset_req_ready", int'(req_ready), 1);
    req_valid = 1'b1;
    req_x     = 10'd216;
    req_y     = 10'd240;
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    repeat (29) @(negedge CLOCK_50);
    chk("issue_at_cycle30", int'(rd_en), 1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    chk("mid_reset_rd_en", int'(rd_en), 0);
    chk("mid_reset_rd_address", int'(rd_address), 0);
    chk("mid_reset_req_ready", int'(req_ready), 1);
    chk("mid_reset_rsp_valid", int'(rsp_valid), 0);
    seen = 1'b0;
    repeat (80) begin
      @(negedge CLOCK_50);
      if (rsp_valid || rd_en) seen = 1'b1;
    end
    chk("no_activity_after_reset", int'(seen), 0);

    push_req(216, 240, 0, 0, 0, 67, 64);
    collect(0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cell_collision_reader.md
Name: cell_collision_reader

Overview:
- Read-side companion to the trail writer. Serves a request to scan one player-sized cell (CELL_W x CELL_H pixels) at (x,y) in the shared 640x480 8-bit framebuffer RAM.
- Reads the cell through the RAM read port and reports whether any pixel is non-zero, along with the first non-zero value, which identifies whose trail was hit.
- Sits between the player movement logic, which issues the future position, and the framebuffer read port. Replaces the per-pixel compare done during scan-out.

Parameters:
- H_RES, 640, framebuffer line stride in pixels
- CELL_W, 8, cell width in pixels
- CELL_H, 8, cell height in pixels
- ARENA_MIN_X, 16, leftmost legal pixel column
- ARENA_MAX_X, 623, rightmost legal pixel column
- ARENA_MIN_Y, 16, top legal pixel row
- ARENA_MAX_Y, 463, bottom legal pixel row
- RD_LATENCY, 2, RAM read latency in cycles from rd_address/rd_en to valid rd_data (>=1)
- ADDR_W, 19, RAM address width
- DATA_W, 8, RAM data width

Ports:
- CLOCK_50  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when valid&ready
- req_x  in  10  cell top-left column
- req_y  in  10  cell top-left row
- rd_en  out  1  read strobe to RAM read port
- rd_address  out  ADDR_W  RAM read address
- rd_data  in  DATA_W  RAM read data, valid RD_LATENCY cycles after rd_en
- rsp_valid  out  1  result present, held until rsp_ready
- rsp_ready  in  1  consumer accepts result
- rsp_hit  out  1  collision (non-zero pixel or out of arena)
- rsp_oob  out  1  cell not fully inside arena
- rsp_data  out  DATA_W  first non-zero pixel in row-major order; 0 if none or oob

Behaviour:
- Reset values: req_ready=1, rd_en=0, rd_address=0, rsp_valid=0, rsp_hit=0, rsp_oob=0, rsp_data=0, state=IDLE. Any in-flight read tags are cleared.
- States:
  - IDLE: req_ready=1. On accept, latch x/y and compute oob using 11-bit arithmetic so there is no wrap:
    - oob = x<ARENA_MIN_X | x+CELL_W-1>ARENA_MAX_X | y<ARENA_MIN_Y | y+CELL_H-1>ARENA_MAX_Y
    - If oob: go to RESP with hit=1, oob=1, data=0. No RAM reads are issued.
    - Otherwise: row_base = x + y*H_RES, col=0, row=0, go to ISSUE.
  - ISSUE: rd_en=1, rd_address=row_base+col, one read per cycle, CELL_W*CELL_H cycles, row-major order.
    - At col=CELL_W-1: col=0, row_base+=H_RES (adder only, no multiplier in the loop).
    - After the last read, go to DRAIN.
  - DRAIN: rd_en=0. Wait until all in-flight tags have retired, then go to RESP.
  - RESP: rsp_valid=1 and outputs are stable. On rsp_ready, go to IDLE and drop rsp_valid the following cycle.
- Data capture: a valid tag travels RD_LATENCY stages alongside each read.
  - When a tag emerges and rd_data!=0 and hit is not yet set: hit=1, data=rd_data.
  - Later non-zero values do not overwrite data.
  - There is no early termination; latency is deterministic.
- Latency, with the accept edge as cycle 0:
  - Reads on cycles 1..CELL_W*CELL_H.
  - rsp_valid first high on cycle CELL_W*CELL_H+RD_LATENCY+1 (67 with defaults).
  - oob case: rsp_valid high on cycle 1.
- rd_address=0 whenever rd_en=0.
- req_ready=0 in every state except IDLE. A request held while busy is accepted only after the response handshake.
- rsp_ready high in the same cycle rsp_valid rises: the response completes in that cycle.
- Reset mid-operation (any state): return to IDLE next cycle. RAM data returning after reset is ignored and no response is emitted.
- req_x/req_y may change after acceptance with no effect.

Decomposition:
- Shared package tron_pkg holds:
  - screen constants: H_RES, V_RES
  - arena bounds
  - CELL_W/CELL_H
  - ADDR_W/DATA_W
  - state enum: IDLE, ISSUE, DRAIN, RESP
- One sub-module, read_valid_pipe: an RD_LATENCY-deep shift register of rd_en tags. It provides tag_out and a busy (any tag set) signal, with synchronous clear on reset.

Test Plan:
- Clear cell: RAM all 0, req (216,240):
  - rd_address sequence 153816..153823, then 154456.., 64 reads total.
  - rsp_valid at cycle 67, hit=0, oob=0, data=0.
- Last pixel set: RAM[223+247*640]=0x01, req (216,240) -> hit=1, data=0x01, oob=0, still cycle 67.
- First-hit ordering: RAM[218+240*640]=0x80 and RAM[216+241*640]=0x01 -> data=0x80.
- Arena edges:
  - req (616,456) -> fully inside, 64 reads, oob=0.
  - req (617,240) -> rsp_valid cycle 1, hit=1, oob=1, no rd_en.
  - req (8,240) -> oob=1.
  - req (1020,240) -> oob=1, no wrap.
- Backpressure: rsp_ready low for 10 cycles after rsp_valid:
  - outputs stable, req_ready=0, new req_valid ignored.
  - rsp_ready high -> next-cycle IDLE, pending request accepted.
- Reset at ISSUE cycle 30:
  - next cycle rd_en=0, req_ready=1, no rsp_valid.
  - A following req (216,240) with RAM clear returns hit=0 at cycle 67.
